hazard_scoreboard: RTL and testbench

- Sequential hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes the decoder's per-instruction Tuse/Tnew/A3 for the instruction in D and keeps its own shadow copy of in-flight writers in E, M and W, decrementing their Tnew each cycle.
- Produces the D-stage stall and the forwarding selects for rs/rt, and optionally schedules the shared mult/div unit.
- Sits beside the pipeline registers in the CPU top.

---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: D-stage decode info in, stall/forward/mult-div status out.
interface hazard_scoreboard_if;
  logic       flush;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [2:0] d_tuse_rs;
  logic [2:0] d_tuse_rt;
  logic       d_regwrite;
  logic [4:0] d_a3;
  logic [2:0] d_tnew;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       md_busy;

  modport slave (
    input  flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_a3, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs, fwd_rt, md_busy
  );

  modport master (
    output flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_a3, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs, fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard controller for a 5-stage MIPS pipeline. Tracks writers in E/M/W,
// produces the D-stage stall and rs/rt forwarding selects.
// Optional mult/div occupancy scheduling is enabled by defining MD_BUSY_EN.
module hazard_scoreboard #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset_n,
  hazard_scoreboard_if.slave hz
);

  typedef struct packed {
    logic       valid;
    logic [4:0] a3;
    logic [2:0] tnew;
  } entry_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] tnew;
    logic [1:0] code;
  } lookup_t;

  entry_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic   stall_rs, stall_rt, stall_md, stall_raw;
  lookup_t lk_rs, lk_rt;

  function automatic logic [2:0] sat_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

  function automatic logic match(input entry_t e, input logic [4:0] r);
    return e.valid && (e.a3 == r) && (r != 5'd0);
  endfunction

  // Youngest matching stage wins; older stale writers are shadowed.
  function automatic lookup_t lookup(input entry_t e, input entry_t m, input entry_t w,
                                     input logic [4:0] r);
    lookup_t res;
    res = '0;
    if (match(e, r)) begin
      res = '{hit: 1'b1, tnew: e.tnew, code: 2'd1};
    end else if (match(m, r)) begin
      res = '{hit: 1'b1, tnew: m.tnew, code: 2'd2};
    end else if (match(w, r)) begin
      res = '{hit: 1'b1, tnew: w.tnew, code: 2'd3};
    end
    return res;
  endfunction

`ifdef MD_BUSY_EN
  logic [3:0] md_cnt_q, md_cnt_d;

  // Mult/div occupancy: load on issue into E, count down to idle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hz.flush) begin
      md_cnt_d = 4'd0;
    end else if (!stall_raw && hz.d_md_start) begin
      md_cnt_d = hz.d_md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  // Mult/div counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.md_busy = (md_cnt_q != 4'd0);
  assign stall_md   = hz.d_md_use && hz.md_busy;
`else
  // Mult/div treated as single-cycle: nothing to schedule.
  logic md_unused;
  assign md_unused  = ^{hz.d_md_start, hz.d_md_div, hz.d_md_use,
                        4'(MULT_CYCLES), 4'(DIV_CYCLES)};
  assign hz.md_busy = 1'b0;
  assign stall_md   = 1'b0;
`endif

  // Hazard detection and forwarding selects; flush masks both.
  always_comb begin
    lk_rs     = lookup(e_q, m_q, w_q, hz.d_rs);
    lk_rt     = lookup(e_q, m_q, w_q, hz.d_rt);
    stall_rs  = lk_rs.hit && (lk_rs.tnew > hz.d_tuse_rs);
    stall_rt  = lk_rt.hit && (lk_rt.tnew > hz.d_tuse_rt);
    stall_raw = !hz.flush && (stall_rs || stall_rt || stall_md);
    hz.stall  = stall_raw;
    hz.fwd_rs = 2'd0;
    hz.fwd_rt = 2'd0;
    if (!hz.flush) begin
      if (lk_rs.hit && lk_rs.tnew == 3'd0) hz.fwd_rs = lk_rs.code;
      if (lk_rt.hit && lk_rt.tnew == 3'd0) hz.fwd_rt = lk_rt.code;
    end
  end

  // Shadow pipeline advance: age writers, admit D or a bubble into E.
  always_comb begin
    w_d = '{valid: m_q.valid, a3: m_q.a3, tnew: sat_dec(m_q.tnew)};
    m_d = '{valid: e_q.valid, a3: e_q.a3, tnew: sat_dec(e_q.tnew)};
    e_d = '0;
    if (!stall_raw) begin
      e_d = '{valid: hz.d_regwrite && (hz.d_a3 != 5'd0), a3: hz.d_a3, tnew: hz.d_tnew};
    end
    if (hz.flush) begin
      e_d = '0;
      m_d = '0;
      w_d = '0;
    end
  end

  // Stage entry registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  hazard_scoreboard_if hz ();

  hazard_scoreboard #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .hz     (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] trs,
                       input logic [2:0] trt, input logic rw, input logic [4:0] a3,
                       input logic [2:0] tnew);
    hz.d_rs       = rs;
    hz.d_rt       = rt;
    hz.d_tuse_rs  = trs;
    hz.d_tuse_rt  = trt;
    hz.d_regwrite = rw;
    hz.d_a3       = a3;
    hz.d_tnew     = tnew;
    hz.d_md_start = 1'b0;
    hz.d_md_div   = 1'b0;
    hz.d_md_use   = 1'b0;
    hz.flush      = 1'b0;
  endtask

  // Advance one clock, then let combinational outputs settle after new drives.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    repeat (4) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(5'd1, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    #12;
    chk("reset_stall", {3'd0, hz.stall}, 4'd0);
    chk("reset_fwd_rs", {2'd0, hz.fwd_rs}, 4'd0);
    chk("reset_fwd_rt", {2'd0, hz.fwd_rt}, 4'd0);
    chk("reset_md_busy", {3'd0, hz.md_busy}, 4'd0);
    reset_n = 1'b1;
    step();

    // lw $1 (tnew=2), then addu using $1 (tuse=1)
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd1, 3'd2);
    #1 chk("lw_issue_stall", {3'd0, hz.stall}, 4'd0);
    step();
    drive(5'd1, 5'd0, 3'd1, 3'd0, 1'b1, 5'd4, 3'd1);
    #1 chk("lw_use_stall1", {3'd0, hz.stall}, 4'd1);
    step();
    #1 chk("lw_use_stall2", {3'd0, hz.stall}, 4'd0);
    chk("lw_use_fwd_m_notready", {2'd0, hz.fwd_rs}, 4'd0);
    step();
    // lw now in W with tnew=0; addu in E writes $4, not $1
    drive(5'd1, 5'd0, 3'd1, 3'd0, 1'b0, 5'd0, 3'd0);
    #1 chk("lw_fwd_w_stall", {3'd0, hz.stall}, 4'd0);
    chk("lw_fwd_w", {2'd0, hz.fwd_rs}, 4'd3);
    drain();

    // addu $1 (tnew=1), then beq $1,$1 (tuse=0)
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd1, 3'd1);
    step();
    drive(5'd1, 5'd1, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    #1 chk("beq_stall1", {3'd0, hz.stall}, 4'd1);
    step();
    #1 chk("beq_stall2", {3'd0, hz.stall}, 4'd0);
    chk("beq_fwd_rs", {2'd0, hz.fwd_rs}, 4'd2);
    chk("beq_fwd_rt", {2'd0, hz.fwd_rt}, 4'd2);
    drain();

    // Two ready writers to $3 in E and M: E wins
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd3, 3'd0);
    step();
    step();
    drive(5'd0, 5'd3, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    #1 chk("young_stall", {3'd0, hz.stall}, 4'd0);
    chk("young_fwd_rt", {2'd0, hz.fwd_rt}, 4'd1);
    drain();

    // Stale older writer (M tnew=1) shadowed by ready E writer to $5
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd5, 3'd2);
    step();
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd5, 3'd0);
    step();
    drive(5'd5, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    #1 chk("stale_stall", {3'd0, hz.stall}, 4'd0);
    chk("stale_fwd_rs", {2'd0, hz.fwd_rs}, 4'd1);
    drain();

    // Writer to $0 never matches
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd0, 3'd2);
    step();
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    #1 chk("zero_stall", {3'd0, hz.stall}, 4'd0);
    chk("zero_fwd_rs", {2'd0, hz.fwd_rs}, 4'd0);
    chk("zero_fwd_rt", {2'd0, hz.fwd_rt}, 4'd0);
    drain();

    // Dependent lw in E with flush asserted
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd1, 3'd2);
    step();
    drive(5'd1, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    hz.flush = 1'b1;
    #1 chk("flush_stall", {3'd0, hz.stall}, 4'd0);
    chk("flush_fwd_rs", {2'd0, hz.fwd_rs}, 4'd0);
    step();
    hz.flush = 1'b0;
    #1 chk("post_flush_stall", {3'd0, hz.stall}, 4'd0);
    chk("post_flush_fwd_rs", {2'd0, hz.fwd_rs}, 4'd0);
    chk("post_flush_md_busy", {3'd0, hz.md_busy}, 4'd0);
    drain();

    // Mult then mflo; div then mflo
    for (int k = 0; k < 2; k++) begin
      drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
      hz.d_md_start = 1'b1;
      hz.d_md_div   = (k == 1);
      hz.d_md_use   = 1'b1;
      #1 chk("md_issue_stall", {3'd0, hz.stall}, 4'd0);
      step();
      drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b1, 5'd2, 3'd1);
      hz.d_md_use = 1'b1;
`ifdef MD_BUSY_EN
      for (int c = 0; c < ((k == 1) ? 10 : 5); c++) begin
        #1 chk("md_busy_on", {3'd0, hz.md_busy}, 4'd1);
        chk("md_stall_on", {3'd0, hz.stall}, 4'd1);
        step();
      end
`endif
      #1 chk("md_busy_off", {3'd0, hz.md_busy}, 4'd0);
      chk("md_stall_off", {3'd0, hz.stall}, 4'd0);
      drain();
    end

`ifdef MD_BUSY_EN
    // Flush cancels an in-progress divide
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    hz.d_md_start = 1'b1;
    hz.d_md_div   = 1'b1;
    hz.d_md_use   = 1'b1;
    step();
    drive(5'd0, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    hz.d_md_use = 1'b1;
    hz.flush    = 1'b1;
    #1 chk("md_flush_stall", {3'd0, hz.stall}, 4'd0);
    step();
    hz.flush = 1'b0;
    #1 chk("md_flush_busy", {3'd0, hz.md_busy}, 4'd0);
    chk("md_flush_stall_after", {3'd0, hz.stall}, 4'd0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
